neuron_integrator: RTL and testbench

//  Leaky integrate-and-fire compute stage directly downstream of neuron_parameters. Per timestep it

---
 rtl/neuron_integrator.sv | 144 ++++++++++++++
 tb/tb_neuron_integrator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/neuron_integrator.sv
// Leaky integrate-and-fire stage: scans one axon per cycle into a 16-bit accumulator,
// applies leak, checks thresholds and issues a one-cycle write-back/spike strobe.
module neuron_integrator #(
    parameter int NUM_AXONS = 256
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   start_i,
    input  logic [NUM_AXONS-1:0]   axon_spikes_i,
    input  logic [NUM_AXONS-1:0]   connections_i,
    input  logic [2*NUM_AXONS-1:0] axon_types_i,
    input  logic [7:0]             voltage_potential_i,
    input  logic [7:0]             pos_threshold_i,
    input  logic [7:0]             neg_threshold_i,
    input  logic [7:0]             leak_value_i,
    input  logic [7:0]             weight_type1_i,
    input  logic [7:0]             weight_type2_i,
    input  logic [7:0]             weight_type3_i,
    input  logic [7:0]             weight_type4_i,
    input  logic [7:0]             weight_select_i,
    input  logic [7:0]             pos_reset_i,
    input  logic [7:0]             neg_reset_i,
    output logic [7:0]             ext_voltage_potential_o,
    output logic                   ext_write_enable_o,
    output logic                   spike_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int AW = $clog2(NUM_AXONS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_AXONS - 1);

    typedef enum logic [2:0] {IDLE, INTEGRATE, LEAK, FIRE, WRITE} state_t;

    state_t                 state;
    logic [NUM_AXONS-1:0]   spikes_q, conn_q;
    logic [2*NUM_AXONS-1:0] types_q;
    logic [3:0][7:0]        weight_q;
    logic [3:0]             sel_q;
    logic [7:0]             leak_q, pos_th_q, neg_th_q, pos_reset_q, neg_reset_q;
    logic signed [15:0]     acc;
    logic [AW-1:0]          idx;

    // Upper select bits carry no meaning for this block.
    logic unused_sel;
    assign unused_sel = ^weight_select_i[7:4];

    logic [1:0]         cur_type;
    logic               cur_hit;
    logic [7:0]         cur_w8;
    logic signed [15:0] cur_weight, leak_ext, pos_th_ext, neg_th_ext;
    logic [7:0]         fire_v;
    logic               fire_spk;

    always_comb begin
        cur_type   = types_q[{idx, 1'b0} +: 2];
        cur_hit    = spikes_q[idx] & conn_q[idx] & sel_q[cur_type];
        cur_w8     = weight_q[cur_type];
        cur_weight = {{8{cur_w8[7]}}, cur_w8};
        leak_ext   = {{8{leak_q[7]}}, leak_q};
        pos_th_ext = {{8{pos_th_q[7]}}, pos_th_q};
        neg_th_ext = {{8{neg_th_q[7]}}, neg_th_q};
        fire_spk   = 1'b0;
        // Positive threshold wins when both conditions hold.
        if (acc >= pos_th_ext) begin
            fire_v   = pos_reset_q;
            fire_spk = 1'b1;
        end else if (acc < neg_th_ext) begin
            fire_v = neg_reset_q;
        end else if (acc > 16'sd127) begin
            fire_v = 8'h7f;
        end else if (acc < -16'sd128) begin
            fire_v = 8'h80;
        end else begin
            fire_v = acc[7:0];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state                   <= IDLE;
            spikes_q                <= '0;
            conn_q                  <= '0;
            types_q                 <= '0;
            weight_q                <= '0;
            sel_q                   <= '0;
            leak_q                  <= '0;
            pos_th_q                <= '0;
            neg_th_q                <= '0;
            pos_reset_q             <= '0;
            neg_reset_q             <= '0;
            acc                     <= '0;
            idx                     <= '0;
            ext_voltage_potential_o <= '0;
            ext_write_enable_o      <= 1'b0;
            spike_o                 <= 1'b0;
            busy_o                  <= 1'b0;
            done_o                  <= 1'b0;
        end else begin
            ext_write_enable_o <= 1'b0;
            spike_o            <= 1'b0;
            done_o             <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    spikes_q    <= axon_spikes_i;
                    conn_q      <= connections_i;
                    types_q     <= axon_types_i;
                    weight_q    <= {weight_type4_i, weight_type3_i, weight_type2_i, weight_type1_i};
                    sel_q       <= weight_select_i[3:0];
                    leak_q      <= leak_value_i;
                    pos_th_q    <= pos_threshold_i;
                    neg_th_q    <= neg_threshold_i;
                    pos_reset_q <= pos_reset_i;
                    neg_reset_q <= neg_reset_i;
                    acc         <= {{8{voltage_potential_i[7]}}, voltage_potential_i};
                    idx         <= '0;
                    busy_o      <= 1'b1;
                    state       <= INTEGRATE;
                end
                INTEGRATE: begin
                    if (cur_hit) acc <= acc + cur_weight;
                    if (idx == LAST_IDX) state <= LEAK;
                    else                 idx   <= idx + AW'(1);
                end
                LEAK: begin
                    acc   <= acc + leak_ext;
                    state <= FIRE;
                end
                // Outputs register here so they are visible throughout the WRITE cycle.
                FIRE: begin
                    ext_voltage_potential_o <= fire_v;
                    spike_o                 <= fire_spk;
                    ext_write_enable_o      <= 1'b1;
                    done_o                  <= 1'b1;
                    state                   <= WRITE;
                end
                WRITE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_integrator.sv
// Self-checking bench for neuron_integrator: directed LIF cases plus randomized timesteps
// compared against a plain-arithmetic reference model.
module tb_neuron_integrator;
    localparam int N = 4;

    logic           tb_clk = 1'b0;
    logic           rst_n  = 1'b0;
    logic           start_i = 1'b0;
    logic [N-1:0]   axon_spikes_i = '0, connections_i = '0;
    logic [2*N-1:0] axon_types_i = '0;
    logic [7:0]     voltage_potential_i = '0, pos_threshold_i = '0, neg_threshold_i = '0;
    logic [7:0]     leak_value_i = '0, weight_select_i = '0, pos_reset_i = '0, neg_reset_i = '0;
    logic [7:0]     weight_type1_i = '0, weight_type2_i = '0, weight_type3_i = '0, weight_type4_i = '0;
    logic [7:0]     ext_voltage_potential_o;
    logic           ext_write_enable_o, spike_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    always #5 tb_clk = ~tb_clk;

    neuron_integrator #(.NUM_AXONS(N)) dut (
        .wb_clk_i(tb_clk), .wb_rst_ni(rst_n), .start_i(start_i),
        .axon_spikes_i(axon_spikes_i), .connections_i(connections_i), .axon_types_i(axon_types_i),
        .voltage_potential_i(voltage_potential_i), .pos_threshold_i(pos_threshold_i),
        .neg_threshold_i(neg_threshold_i), .leak_value_i(leak_value_i),
        .weight_type1_i(weight_type1_i), .weight_type2_i(weight_type2_i),
        .weight_type3_i(weight_type3_i), .weight_type4_i(weight_type4_i),
        .weight_select_i(weight_select_i), .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i),
        .ext_voltage_potential_o(ext_voltage_potential_o), .ext_write_enable_o(ext_write_enable_o),
        .spike_o(spike_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: sum the weights of eligible axons onto V, add leak, then apply thresholds.
    function automatic void model(output int v, output int spk);
        int acc, w[4], t;
        w[0] = int'($signed(weight_type1_i)); w[1] = int'($signed(weight_type2_i));
        w[2] = int'($signed(weight_type3_i)); w[3] = int'($signed(weight_type4_i));
        acc = int'($signed(voltage_potential_i));
        for (int a = 0; a < N; a++) begin
            t = int'(axon_types_i[2*a +: 2]);
            if (axon_spikes_i[a] && connections_i[a] && weight_select_i[t]) acc += w[t];
        end
        acc += int'($signed(leak_value_i));
        spk = 0;
        if (acc >= int'($signed(pos_threshold_i))) begin
            v = int'($signed(pos_reset_i)); spk = 1;
        end else if (acc < int'($signed(neg_threshold_i))) v = int'($signed(neg_reset_i));
        else if (acc > 127)  v = 127;
        else if (acc < -128) v = -128;
        else v = acc;
    endfunction

    task automatic scramble();
        axon_spikes_i       = N'($urandom);
        connections_i       = N'($urandom);
        axon_types_i        = (2*N)'($urandom);
        voltage_potential_i = 8'($urandom);
        pos_threshold_i     = 8'($urandom);
        neg_threshold_i     = 8'($urandom);
        leak_value_i        = 8'($urandom);
        weight_type1_i      = 8'($urandom);
        weight_type2_i      = 8'($urandom);
        weight_type3_i      = 8'($urandom);
        weight_type4_i      = 8'($urandom);
        weight_select_i     = 8'($urandom);
        pos_reset_i         = 8'($urandom);
        neg_reset_i         = 8'($urandom);
    endtask

    // One timestep; disturb pulses start again at cycle 2 and rewrites every input mid-run.
    task automatic run(input string tag, input bit disturb);
        int exp_v, exp_s, cyc, extra;
        model(exp_v, exp_s);
        @(negedge tb_clk); start_i = 1'b1;
        @(negedge tb_clk); start_i = 1'b0; cyc = 1;
        chk({tag, ":busy_run"}, int'(busy_o), 1);
        while (!done_o && cyc < 40) begin
            @(negedge tb_clk); cyc++;
            if (disturb && cyc == 2) begin start_i = 1'b1; scramble(); end
            if (disturb && cyc == 3) start_i = 1'b0;
        end
        chk({tag, ":latency"}, cyc, N + 3);
        chk({tag, ":v"}, int'($signed(ext_voltage_potential_o)), exp_v);
        chk({tag, ":we"}, int'(ext_write_enable_o), 1);
        chk({tag, ":spike"}, int'(spike_o), exp_s);
        chk({tag, ":busy_done"}, int'(busy_o), 1);
        @(negedge tb_clk);
        chk({tag, ":strobes_off"}, int'({done_o, ext_write_enable_o, spike_o, busy_o}), 0);
        chk({tag, ":v_hold"}, int'($signed(ext_voltage_potential_o)), exp_v);
        extra = 0;
        repeat (5) begin @(negedge tb_clk); extra += int'(done_o | ext_write_enable_o); end
        chk({tag, ":no_extra"}, extra, 0);
    endtask

    task automatic setup(input logic [7:0] v, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] sel, input logic [2*N-1:0] types, input logic [N-1:0] spk,
                         input logic [7:0] leak, input logic [7:0] pth, input logic [7:0] nth,
                         input logic [7:0] pr, input logic [7:0] nr);
        voltage_potential_i = v; weight_type1_i = w1; weight_type2_i = w2;
        weight_type3_i = 8'd0; weight_type4_i = 8'd0; weight_select_i = sel;
        axon_types_i = types; axon_spikes_i = spk; connections_i = {N{1'b1}};
        leak_value_i = leak; pos_threshold_i = pth; neg_threshold_i = nth;
        pos_reset_i = pr; neg_reset_i = nr;
    endtask

    initial begin
        int seen;
        // Reset held: start toggling must not produce anything.
        repeat (2) begin
            @(negedge tb_clk); start_i = 1'b1;
            @(negedge tb_clk); start_i = 1'b0;
        end
        chk("rst:outs", int'({ext_voltage_potential_o, ext_write_enable_o, spike_o, busy_o, done_o}), 0);
        @(negedge tb_clk); rst_n = 1'b1;
        @(negedge tb_clk);
        chk("rst:idle_busy", int'(busy_o), 0);
        chk("rst:idle_done", int'(done_o), 0);

        setup(8'd10, 8'd5, -8'sd3, 8'h0F, 8'b01_00_01_00, 4'b1111, -8'sd1, 8'd100, -8'sd50, 8'd0, 8'd0);
        chk("model:t2", int'($signed(8'd13)), 13);
        run("integ", 1'b0);
        setup(8'd90, 8'd20, 8'd0, 8'h0F, 8'b0, 4'b0001, 8'd0, 8'd100, -8'sd50, 8'd0, 8'd0);
        run("fire", 1'b0);
        setup(-8'sd40, 8'd0, -8'sd30, 8'h0F, 8'b00_00_00_01, 4'b0001, 8'd0, 8'd100, -8'sd60, 8'd0, -8'sd5);
        run("negrst", 1'b0);
        setup(-8'sd40, 8'd0, -8'sd30, 8'h00, 8'b00_00_00_01, 4'b0001, 8'd0, 8'd100, -8'sd60, 8'd0, -8'sd5);
        run("masked", 1'b0);
        setup(8'd100, 8'd50, 8'd0, 8'h0F, 8'b0, 4'b0001, 8'd0, 8'd127, -8'sd60, 8'd7, 8'd0);
        run("posbig", 1'b0);
        setup(-8'sd100, 8'd0, -8'sd100, 8'h0F, 8'b00_00_00_01, 4'b0001, 8'd0, 8'd100, -8'sd128, 8'd0, -8'sd128);
        run("negbig", 1'b0);
        setup(8'd10, 8'd5, -8'sd3, 8'h0F, 8'b01_00_01_00, 4'b1111, -8'sd1, 8'd100, -8'sd50, 8'd0, 8'd0);
        run("busy_ign", 1'b1);

        // Reset in the middle of integration aborts silently.
        scramble();
        @(negedge tb_clk); start_i = 1'b1;
        @(negedge tb_clk); start_i = 1'b0;
        @(negedge tb_clk); rst_n = 1'b0;
        #1 chk("abort:busy", int'(busy_o), 0);
        @(negedge tb_clk); rst_n = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge tb_clk); seen += int'(ext_write_enable_o | spike_o | done_o); end
        chk("abort:no_strobe", seen, 0);
        run("post_abort", 1'b0);

        for (int i = 0; i < 40; i++) begin
            scramble();
            run($sformatf("rnd%0d", i), (i % 4) == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
